// File: rtl/mips_pkg.sv
// Shared MIPS constants and types used by the register file, decode and hazard logic.
package mips_pkg;
  localparam int WIDTH_DEF      = 32;
  localparam int DEPTH_LOG2_DEF = 5;

  typedef logic [4:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_GP   = 5'd28;
  localparam reg_addr_t REG_SP   = 5'd29;
  localparam reg_addr_t REG_RA   = 5'd31;
endpackage

// File: rtl/regfile_read_port.sv
// One combinational register-file read port: zero check plus optional writeback bypass.
module regfile_read_port
  import mips_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter bit BYPASS     = 1'b1
) (
  input  logic [DEPTH_LOG2-1:0]                  addr,
  input  logic [(1<<DEPTH_LOG2)-1:0][WIDTH-1:0]  regs,
  input  logic                                   rst,
  input  logic                                   wr_en,
  input  logic [DEPTH_LOG2-1:0]                  wr_addr,
  input  logic [WIDTH-1:0]                       wr_data,
  output logic [WIDTH-1:0]                       data
);
  logic addr_zero;
  logic byp_hit;

  assign addr_zero = (addr == '0);
  // Bypass is suppressed during reset so a lost write never leaks onto the ALU operands.
  assign byp_hit   = BYPASS && wr_en && !rst && !addr_zero && (wr_addr == addr);

  always_comb begin
    data = '0;
    if (byp_hit)
      data = wr_data;
    else if (!addr_zero)
      data = regs[addr];
  end
endmodule

// File: rtl/mips_register_file.sv
// 32 x 32 MIPS register file: $zero hardwired, two bypassed read ports, one debug port.
module mips_register_file
  import mips_pkg::*;
#(
  parameter int              WIDTH      = WIDTH_DEF,
  parameter int              DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter logic [WIDTH-1:0] SP_INIT   = 32'h0000_3FFC,
  parameter logic [WIDTH-1:0] GP_INIT   = 32'h0000_1800
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DEPTH_LOG2-1:0] read_reg1,
  input  logic [DEPTH_LOG2-1:0] read_reg2,
  input  logic [DEPTH_LOG2-1:0] write_reg,
  input  logic [WIDTH-1:0]      write_data,
  input  logic                  reg_write,
  input  logic [DEPTH_LOG2-1:0] dbg_reg,
  output logic [WIDTH-1:0]      read1,
  output logic [WIDTH-1:0]      read2,
  output logic [WIDTH-1:0]      dbg_data
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DEPTH-1:0][WIDTH-1:0] regs;

  assign regs[0] = '0;

  // Per-register write decode: an unknown write_reg cannot select any other entry.
  for (genvar i = 1; i < DEPTH; i++) begin : g_reg
    localparam logic [WIDTH-1:0] RST_VAL =
      (i == int'(REG_GP)) ? GP_INIT :
      (i == int'(REG_SP)) ? SP_INIT : '0;

    logic [WIDTH-1:0] q;

    always_ff @(posedge clock or posedge reset) begin
      if (reset)
        q <= RST_VAL;
      else if (reg_write && (write_reg == DEPTH_LOG2'(i)))
        q <= write_data;
    end

    assign regs[i] = q;
  end

  regfile_read_port #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2), .BYPASS(1'b1)) u_port1 (
    .addr(read_reg1), .regs(regs), .rst(reset), .wr_en(reg_write),
    .wr_addr(write_reg), .wr_data(write_data), .data(read1)
  );

  regfile_read_port #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2), .BYPASS(1'b1)) u_port2 (
    .addr(read_reg2), .regs(regs), .rst(reset), .wr_en(reg_write),
    .wr_addr(write_reg), .wr_data(write_data), .data(read2)
  );

  regfile_read_port #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2), .BYPASS(1'b0)) u_dbg (
    .addr(dbg_reg), .regs(regs), .rst(reset), .wr_en(reg_write),
    .wr_addr(write_reg), .wr_data(write_data), .data(dbg_data)
  );
endmodule

// File: tb/tb_mips_register_file.sv
// Scoreboard bench for mips_register_file: expected values queued at drive time, popped at check time.
module tb_mips_register_file;
  import mips_pkg::*;

  localparam logic [31:0] SP_INIT = 32'h0000_3FFC;
  localparam logic [31:0] GP_INIT = 32'h0000_1800;

  logic        clock = 1'b0;
  logic        reset;
  reg_addr_t   read_reg1, read_reg2, write_reg, dbg_reg;
  logic [31:0] write_data;
  logic        reg_write;
  logic [31:0] read1, read2, dbg_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp;
  logic [31:0] mdl [32];

  always #5 clock = ~clock;

  mips_register_file dut (
    .clock(clock), .reset(reset),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
    .dbg_reg(dbg_reg),
    .read1(read1), .read2(read2), .dbg_data(dbg_data)
  );

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    mdl[28] = GP_INIT;
    mdl[29] = SP_INIT;
  endtask

  task automatic do_write(input reg_addr_t a, input logic [31:0] d);
    @(negedge clock);
    reg_write = 1'b1; write_reg = a; write_data = d;
    @(posedge clock);
    @(negedge clock);
    reg_write = 1'b0;
    if (a != 5'd0) mdl[a] = d;
  endtask

  task automatic test_reset();
    reset = 1'b1; reg_write = 1'b0; write_reg = '0; write_data = '0;
    read_reg1 = 5'd29; read_reg2 = 5'd28; dbg_reg = 5'd5;
    model_reset();
    exp_q.push_back(SP_INIT); exp_q.push_back(GP_INIT); exp_q.push_back(32'h0);
    #3;
    exp = exp_q.pop_front(); n_checks++;
    if (read1 !== exp) begin n_fail++; $display("FAIL reset_r29 got=%h want=%h", read1, exp); end
    exp = exp_q.pop_front(); n_checks++;
    if (read2 !== exp) begin n_fail++; $display("FAIL reset_r28 got=%h want=%h", read2, exp); end
    exp = exp_q.pop_front(); n_checks++;
    if (dbg_data !== exp) begin n_fail++; $display("FAIL reset_r5 got=%h want=%h", dbg_data, exp); end
    @(negedge clock);
    reset = 1'b0;
    do_write(5'd5, 32'd7);
    dbg_reg = 5'd5;
    exp_q.push_back(32'd7);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (dbg_data !== exp) begin n_fail++; $display("FAIL prewrite_r5 got=%h want=%h", dbg_data, exp); end
    // Asynchronous reset between edges: contents must change with no clock edge.
    #1;
    reset = 1'b1;
    read_reg1 = 5'd5; read_reg2 = 5'd29; dbg_reg = 5'd28;
    model_reset();
    exp_q.push_back(32'h0); exp_q.push_back(SP_INIT); exp_q.push_back(GP_INIT);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (read1 !== exp) begin n_fail++; $display("FAIL async_r5 got=%h want=%h", read1, exp); end
    exp = exp_q.pop_front(); n_checks++;
    if (read2 !== exp) begin n_fail++; $display("FAIL async_r29 got=%h want=%h", read2, exp); end
    exp = exp_q.pop_front(); n_checks++;
    if (dbg_data !== exp) begin n_fail++; $display("FAIL async_r28 got=%h want=%h", dbg_data, exp); end
    read_reg1 = 5'd0;
    exp_q.push_back(32'h0);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (read1 !== exp) begin n_fail++; $display("FAIL async_r0 got=%h want=%h", read1, exp); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    do_write(5'd8, 32'd50);
    do_write(5'd9, 32'd30);
    read_reg1 = 5'd8; read_reg2 = 5'd9;
    exp_q.push_back(32'd50); exp_q.push_back(32'd30); exp_q.push_back(32'd80);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (read1 !== exp) begin n_fail++; $display("FAIL rd_r8 got=%0d want=%0d", read1, exp); end
    exp = exp_q.pop_front(); n_checks++;
    if (read2 !== exp) begin n_fail++; $display("FAIL rd_r9 got=%0d want=%0d", read2, exp); end
    exp = exp_q.pop_front(); n_checks++;
    if (read1 + read2 !== exp) begin n_fail++; $display("FAIL alu_add got=%0d want=%0d", read1 + read2, exp); end
  endtask

  task automatic test_zero_write();
    @(negedge clock);
    reg_write = 1'b1; write_reg = 5'd0; write_data = 32'hDEAD_BEEF;
    read_reg1 = 5'd0; read_reg2 = 5'd0; dbg_reg = 5'd0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (read1 !== exp) begin n_fail++; $display("FAIL zero_before1 got=%h want=%h", read1, exp); end
    exp = exp_q.pop_front(); n_checks++;
    if (read2 !== exp) begin n_fail++; $display("FAIL zero_before2 got=%h want=%h", read2, exp); end
    @(posedge clock);
    @(negedge clock);
    reg_write = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (read1 !== exp) begin n_fail++; $display("FAIL zero_after got=%h want=%h", read1, exp); end
    exp = exp_q.pop_front(); n_checks++;
    if (dbg_data !== exp) begin n_fail++; $display("FAIL zero_dbg got=%h want=%h", dbg_data, exp); end
  endtask

  task automatic test_bypass();
    do_write(5'd12, 32'd4);
    reg_write = 1'b1; write_reg = 5'd12; write_data = 32'd99;
    read_reg1 = 5'd12; read_reg2 = 5'd12; dbg_reg = 5'd12;
    exp_q.push_back(32'd99); exp_q.push_back(32'd99); exp_q.push_back(32'd4);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (read1 !== exp) begin n_fail++; $display("FAIL byp_read1 got=%0d want=%0d", read1, exp); end
    exp = exp_q.pop_front(); n_checks++;
    if (read2 !== exp) begin n_fail++; $display("FAIL byp_read2 got=%0d want=%0d", read2, exp); end
    exp = exp_q.pop_front(); n_checks++;
    if (dbg_data !== exp) begin n_fail++; $display("FAIL byp_dbg_old got=%0d want=%0d", dbg_data, exp); end
    @(posedge clock);
    @(negedge clock);
    reg_write = 1'b0;
    mdl[12] = 32'd99;
    exp_q.push_back(32'd99);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (dbg_data !== exp) begin n_fail++; $display("FAIL byp_dbg_new got=%0d want=%0d", dbg_data, exp); end
  endtask

  task automatic test_no_write();
    @(negedge clock);
    reg_write = 1'b0; write_reg = 5'd3; write_data = 32'd123;
    read_reg1 = 5'd3; dbg_reg = 5'd3;
    exp_q.push_back(mdl[3]);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (read1 !== exp) begin n_fail++; $display("FAIL nowr_nobyp got=%0d want=%0d", read1, exp); end
    repeat (3) @(posedge clock);
    @(negedge clock);
    exp_q.push_back(mdl[3]);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (dbg_data !== exp) begin n_fail++; $display("FAIL nowr_r3 got=%0d want=%0d", dbg_data, exp); end
  endtask

  task automatic test_reset_mid_write();
    @(negedge clock);
    reg_write = 1'b1; write_reg = 5'd29; write_data = 32'd77;
    read_reg1 = 5'd29; dbg_reg = 5'd29;
    reset = 1'b1;
    model_reset();
    exp_q.push_back(SP_INIT);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (read1 !== exp) begin n_fail++; $display("FAIL rstwr_nobyp got=%h want=%h", read1, exp); end
    @(posedge clock);
    @(negedge clock);
    reg_write = 1'b0;
    reset = 1'b0;
    exp_q.push_back(SP_INIT); exp_q.push_back(SP_INIT);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (dbg_data !== exp) begin n_fail++; $display("FAIL rstwr_dbg got=%h want=%h", dbg_data, exp); end
    exp = exp_q.pop_front(); n_checks++;
    if (read1 !== exp) begin n_fail++; $display("FAIL rstwr_read1 got=%h want=%h", read1, exp); end
  endtask

  task automatic test_back_to_back();
    reg_addr_t a;
    logic [31:0] d;
    for (int k = 0; k < 40; k++) begin
      a = reg_addr_t'($urandom_range(0, 31));
      d = $urandom;
      @(negedge clock);
      reg_write = 1'b1; write_reg = a; write_data = d;
      read_reg1 = a; read_reg2 = reg_addr_t'(a + 5'd1); dbg_reg = a;
      exp_q.push_back((a == 5'd0) ? 32'h0 : d);
      exp_q.push_back(((a + 5'd1) == 5'd0) ? 32'h0 : mdl[a + 5'd1]);
      exp_q.push_back(mdl[a]);
      #1;
      exp = exp_q.pop_front(); n_checks++;
      if (read1 !== exp) begin n_fail++; $display("FAIL b2b_read1 r%0d got=%h want=%h", a, read1, exp); end
      exp = exp_q.pop_front(); n_checks++;
      if (read2 !== exp) begin n_fail++; $display("FAIL b2b_read2 r%0d got=%h want=%h", a + 5'd1, read2, exp); end
      exp = exp_q.pop_front(); n_checks++;
      if (dbg_data !== exp) begin n_fail++; $display("FAIL b2b_dbg r%0d got=%h want=%h", a, dbg_data, exp); end
      @(posedge clock);
      if (a != 5'd0) mdl[a] = d;
    end
    @(negedge clock);
    reg_write = 1'b0;
    for (int r = 0; r < 32; r++) begin
      dbg_reg = reg_addr_t'(r);
      exp_q.push_back(mdl[r]);
      #1;
      exp = exp_q.pop_front(); n_checks++;
      if (dbg_data !== exp) begin n_fail++; $display("FAIL sweep r%0d got=%h want=%h", r, dbg_data, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_write();
    test_bypass();
    test_no_write();
    test_reset_mid_write();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_register_file.md
Name: mips_register_file

Overview:
- 32 x 32-bit MIPS general-purpose register file; directly upstream of the ALU.
- Outputs read1/read2 drive the ALU operand inputs of the same names.
- Two combinational read ports, one clocked write port from writeback, and a third debug read port for benches.
- $zero is hardwired; same-cycle write-to-read bypass is built in, so the decode stage sees writeback data without an external mux.

Parameters:
- WIDTH, 32, data width of each register and port.
- DEPTH_LOG2, 5, register address width (32 registers).
- SP_INIT, 32'h0000_3FFC, reset value of $sp (register 29).
- GP_INIT, 32'h0000_1800, reset value of $gp (register 28).

Ports:
- clock  in  1  single system clock; all writes occur on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- read_reg1  in  5  address for read port 1 (rs).
- read_reg2  in  5  address for read port 2 (rt).
- write_reg  in  5  write address (rd/rt from writeback).
- write_data  in  32  write data.
- reg_write  in  1  write enable.
- dbg_reg  in  5  debug read address.
- read1  out  32  read port 1 data; feeds ALU read1.
- read2  out  32  read port 2 data; feeds ALU read2.
- dbg_data  out  32  debug port data, without bypass.

Behaviour:
- Storage: 31 physical 32-bit registers (1..31). Register 0 has no storage and always reads 0.
- Reset:
  - Asynchronous and active-high; assertion takes effect immediately, without waiting for a clock edge.
  - All registers clear to 0, except r28 = GP_INIT and r29 = SP_INIT.
  - While reset is high, writes are ignored and reads return the reset contents (r28/r29 nonzero, others 0).
  - Bypass is disabled while reset is high.
- Write:
  - On rising clock with reset low, reg_write = 1 and write_reg != 0: reg[write_reg] <= write_data.
  - A write to address 0 is silently discarded.
  - reg_write = 0 leaves all contents unchanged.
- Read:
  - read1/read2/dbg_data are combinational (zero-cycle latency) from their addresses and the stored contents.
  - Address 0 returns 0.
- Bypass (read1/read2 only):
  - Condition: reg_write = 1, write_reg = read_regN, read_regN != 0, reset low.
  - When the condition holds, read_regN returns write_data in the same cycle, before the clock edge commits it.
  - Both ports may bypass simultaneously when both addresses equal write_reg.
  - dbg_data never bypasses; it shows committed state only.
- Simultaneous read and write of the same register: bypassed value on read1/read2, old value on dbg_data until the edge.
- Reset mid-write:
  - Reset asserted in the same cycle as a write: the reset value wins and the write is lost.
  - Reset deasserting near an edge is the integrator's responsibility; it must be released synchronously upstream.
- Width rules: no arithmetic; all data passes through at full 32 bits. Addresses are unsigned 5-bit, with no wrap concerns.
- Only the write path contains sequential state: a 31-entry array plus the write-enable decode.
- No X propagation: an unknown address must not corrupt other registers. Implement the write decode as an explicit per-register compare.

Decomposition:
- Shared package mips_pkg holds:
  - REG_ZERO = 0, REG_GP = 28, REG_SP = 29, REG_RA = 31 constants.
  - The WIDTH/DEPTH_LOG2 defaults.
  - A reg_addr_t 5-bit typedef, reused by decode and hazard logic.
- One natural sub-module, regfile_read_port: address-to-data mux with a zero check and an optional bypass compare, instantiated twice with bypass enabled and once (debug port) with bypass disabled.

Test Plan:
- Assert reset mid-run after writing r5=7 -> immediately (no edge) read r5 = 0, read r29 = 32'h3FFC, read r28 = 32'h1800, read r0 = 0.
- Write r8 = 50, r9 = 30 on successive edges, then read_reg1 = 8, read_reg2 = 9 -> read1 = 50, read2 = 30; with ALU control 0010 attached, result = 80.
- reg_write = 1, write_reg = 0, write_data = 32'hDEAD_BEEF, then read_reg1 = 0 -> read1 = 0 before and after the edge; dbg_reg = 0 -> 0.
- Same cycle: reg_write = 1, write_reg = 12, write_data = 99, read_reg1 = read_reg2 = 12 (r12 previously 4) -> read1 = read2 = 99 and dbg_data = 4 before the edge; dbg_data = 99 after.
- reg_write = 0 with write_reg = 3, write_data = 123 over 3 edges -> r3 keeps its prior value (0 after reset).
- Reset asserted in the same cycle as a write of 77 to r29 -> r29 = SP_INIT after reset release; read1 does not bypass 77 while reset is high.
